config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Parameters
REQ-001 CONFIG_WIDTH, default 1602, sets the number of configuration bits presented to the fabric.
REQ-002 WORD_WIDTH, default 8, sets the bits accepted per load beat; legal range is 1..CONFIG_WIDTH.
REQ-003 NUM_WORDS SHALL be the derived constant ceil(CONFIG_WIDTH/WORD_WIDTH); PAD SHALL be NUM_WORDS*WORD_WIDTH-CONFIG_WIDTH.

Interface
REQ-004 config_clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 config_reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a new load.
REQ-007 word_in  in  WORD_WIDTH  bitstream word or checksum word.
REQ-008 word_valid  in  1  word_in is valid this cycle.
REQ-009 word_ready  out  1  loader accepts a word this cycle.
REQ-010 config_data  out  CONFIG_WIDTH  configuration bus to the core.
REQ-011 config_valid  out  1  config_data is complete and verified.
REQ-012 busy  out  1  high in LOAD or CHECK.
REQ-013 error  out  1  last load failed its checksum.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, LOAD, CHECK, DONE and ERROR.
REQ-015 A word SHALL be accepted only on a cycle with word_valid=1 and word_ready=1.
REQ-016 word_ready SHALL be 1 in LOAD and CHECK, and 0 in every other state; words offered in other states SHALL be ignored.
REQ-017 Internal shift register sr is NUM_WORDS*WORD_WIDTH bits wide.
REQ-018 Each word accepted in LOAD SHALL perform sr <= {sr shifted left by WORD_WIDTH, word_in}, so the first word ends up most significant.
REQ-019 config_data SHALL equal sr[CONFIG_WIDTH-1:0] at all times, so the upper PAD bits of the first word are discarded.
REQ-020 A word counter SHALL count accepted LOAD words from 0 to NUM_WORDS-1.
REQ-021 A running checksum SHALL hold the XOR of all words accepted in LOAD.
REQ-022 On acceptance of word NUM_WORDS-1 in LOAD, the FSM SHALL enter CHECK on the next cycle.
REQ-023 The next accepted word (the CHECK word) SHALL be compared with the XOR of all LOAD words, including the last one.
REQ-024 On a checksum match the FSM SHALL enter DONE, and config_valid SHALL be 1 from the following cycle.
REQ-025 On a checksum mismatch the FSM SHALL enter ERROR, set error=1, clear sr to 0 and keep config_valid=0.
REQ-026 DONE and ERROR SHALL hold indefinitely until start or reset.
REQ-027 start in any state SHALL, on the same edge: clear sr, the counter, the checksum, config_valid and error, and enter LOAD.
REQ-028 A start during LOAD or CHECK SHALL abort the current load and restart it.
REQ-029 When start and an accepted word coincide, start SHALL win and the word SHALL be dropped.
REQ-030 config_valid SHALL be 1 only in DONE; config_data outside DONE is not guaranteed meaningful.
REQ-031 Minimum load latency SHALL be NUM_WORDS+1 accepted words; config_valid SHALL rise one cycle after the checksum word is accepted.
REQ-032 Back-to-back words (word_valid held at 1) SHALL be accepted one per cycle with no bubbles.
REQ-033 The counter SHALL be $clog2(NUM_WORDS+1) bits wide and SHALL never wrap within one load.

Reset
REQ-034 config_reset=1 SHALL asynchronously force state=IDLE, sr=0, counter=0, checksum=0, config_valid=0, error=0 and busy=0.
REQ-035 With config_reset=1, word_ready SHALL be 0 and config_data SHALL be all zeros.
REQ-036 Reset asserted mid-load SHALL discard all partial data; no output SHALL change until the next start after release.
REQ-037 Release of reset SHALL take effect synchronously on the first rising config_clock edge after deassertion.

Verification (CONFIG_WIDTH=10, WORD_WIDTH=4, NUM_WORDS=3, PAD=2)
REQ-038 Nominal load: start, then words 0xF,0x5,0xA, then checksum 0x0 -> config_data=10'b11_0101_1010, config_valid=1 one cycle after the checksum word, busy=0.
REQ-039 Bad checksum: words 0x1,0x2,0x3, then checksum 0x1 (expected 0x0) -> error=1, config_data=0, config_valid=0, word_ready=0.
REQ-040 Restart mid-load: words 0x1,0x2, then start, then a full valid load 0x3,0x4,0x5 with checksum 0x2 -> config_data=10'b11_0100_0101, config_valid=1; the first partial load leaves no trace.
REQ-041 Start and word collide: start coincident with word_valid and word 0x7 -> the word is dropped and the counter stays 0; the following three words form the image.
REQ-042 Reset mid-CHECK: assert config_reset after three words -> all outputs 0 immediately, state IDLE; words after release are ignored until start.
REQ-043 Idle/DONE ignore: word_valid pulsed in IDLE and in DONE -> word_ready=0, config_data and config_valid unchanged; a full load with word_valid held continuously completes in 4 accepted cycles.

Source files
------------

// File: rtl/config_loader.sv
// Purpose: serial configuration loader; shifts NUM_WORDS words into an image, verifies an XOR checksum word, presents the image.
// Latency: NUM_WORDS+1 accepted words; config_valid rises the cycle after the checksum word is accepted.
// Backpressure: word_ready is high only while loading or awaiting the checksum; words offered at other times are ignored.
//
// Ports:
//   config_clock  - sole clock, rising edge
//   config_reset  - asynchronous, active-high reset
//   start         - single-cycle pulse; aborts any load in progress and begins a new one
//   word_in       - bitstream word or checksum word (WORD_WIDTH bits)
//   word_valid    - word_in is valid this cycle
//   word_ready    - loader accepts a word this cycle
//   config_data   - configuration image (CONFIG_WIDTH bits)
//   config_valid  - image complete and verified
//   busy          - load or checksum phase in progress
//   error         - last load failed its checksum
module config_loader #(
  parameter int CONFIG_WIDTH = 1602,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    config_clock,
  input  logic                    config_reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    error
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int PAD       = NUM_WORDS * WORD_WIDTH - CONFIG_WIDTH;
  localparam int SR_W      = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                state;
  logic [SR_W-1:0]       sr;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_WIDTH-1:0] chk;
  logic                  accept;
  logic [SR_W-1:0]       sr_shift;

  // Decoded straight from the state register, so these are glitch-free and
  // drop to 0 the instant reset forces IDLE.
  assign word_ready = (state == S_LOAD) || (state == S_CHECK);
  assign busy       = word_ready;
  assign accept     = word_valid && word_ready;

  // Shift written with an operator rather than a slice so a single-word
  // image (SR_W == WORD_WIDTH) stays legal.
  assign sr_shift    = (sr << WORD_WIDTH) | SR_W'(word_in);
  assign config_data = sr[CONFIG_WIDTH-1:0];

  // The top PAD bits only ever hold the discarded high part of the first word.
  generate
    if (PAD > 0) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^sr[SR_W-1:CONFIG_WIDTH];
    end
  endgenerate

  always_ff @(posedge config_clock or posedge config_reset) begin
    if (config_reset) begin
      state        <= S_IDLE;
      sr           <= '0;
      cnt          <= '0;
      chk          <= '0;
      config_valid <= 1'b0;
      error        <= 1'b0;
    end else if (start) begin
      // start outranks everything, including a word accepted on this edge
      state        <= S_LOAD;
      sr           <= '0;
      cnt          <= '0;
      chk          <= '0;
      config_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            sr  <= sr_shift;
            chk <= chk ^ word_in;
            cnt <= cnt + CNT_ONE;
            if (cnt == LAST_CNT) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (word_in == chk) begin
              state        <= S_DONE;
              config_valid <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
              sr    <= '0;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR hold until start or reset
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

  localparam int CW = 10;
  localparam int WW = 4;
  localparam int NW = 3;

  logic          config_clock = 1'b0;
  logic          config_reset;
  logic          start;
  logic [WW-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] config_data;
  logic          config_valid;
  logic          busy;
  logic          error;

  int n_checks = 0;
  int n_errors = 0;

  config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .config_clock (config_clock),
    .config_reset (config_reset),
    .start        (start),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .config_data  (config_data),
    .config_valid (config_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 config_clock = ~config_clock;

  // Reference model: a load is "active" while collecting words; the image is
  // the concatenation of collected words truncated to CW bits.
  bit m_active;
  int m_q[$];
  bit m_valid;
  bit m_err;
  int m_img;

  function automatic int img_of();
    int v = 0;
    foreach (m_q[i]) v = (v * (1 << WW)) + m_q[i];
    return v % (1 << CW);
  endfunction

  function automatic int xor_of();
    int x = 0;
    foreach (m_q[i]) x = x ^ m_q[i];
    return x;
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_q.delete();
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_img    = 0;
  endtask

  task automatic model_edge(input bit r, input bit st, input bit v, input int w);
    if (r) begin
      model_clear();
    end else if (st) begin
      model_clear();
      m_active = 1'b1;
    end else if (m_active && v) begin
      if (m_q.size() < NW) begin
        m_q.push_back(w);
        m_img = img_of();
      end else begin
        m_active = 1'b0;
        if (xor_of() == w) m_valid = 1'b1;
        else begin
          m_err = 1'b1;
          m_img = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".word_ready"},   32'(word_ready),   32'(m_active && !config_reset));
    check({tag, ".config_data"},  32'(config_data),  32'(m_img));
    check({tag, ".config_valid"}, 32'(config_valid), 32'(m_valid));
    check({tag, ".busy"},         32'(busy),         32'(m_active));
    check({tag, ".error"},        32'(error),        32'(m_err));
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, compare.
  task automatic cycle(input bit r, input bit st, input bit v, input logic [WW-1:0] w);
    config_reset = r;
    start        = st;
    word_valid   = v;
    word_in      = w;
    @(posedge config_clock);
    model_edge(r, st, v, int'(w));
    @(negedge config_clock);
    compare_all("cyc");
  endtask

  task automatic load(input logic [WW-1:0] a, input logic [WW-1:0] b,
                      input logic [WW-1:0] c, input logic [WW-1:0] k);
    cycle(0, 0, 1, a);
    cycle(0, 0, 1, b);
    cycle(0, 0, 1, c);
    cycle(0, 0, 1, k);
  endtask

  initial begin
    config_reset = 1'b1;
    start        = 1'b0;
    word_valid   = 1'b0;
    word_in      = '0;
    model_clear();
    @(negedge config_clock);
    compare_all("reset");
    cycle(1, 0, 1, 4'h9);
    check("reset.data_zero", 32'(config_data), 32'h0);
    check("reset.ready_zero", 32'(word_ready), 32'h0);
    cycle(0, 0, 0, 4'h0);

    // IDLE ignores words
    cycle(0, 0, 1, 4'hC);
    check("idle.ignore_ready", 32'(word_ready), 32'h0);
    check("idle.ignore_data", 32'(config_data), 32'h0);

    // Nominal load
    cycle(0, 1, 0, 4'h0);
    cycle(0, 0, 1, 4'hF);
    cycle(0, 0, 1, 4'h5);
    cycle(0, 0, 1, 4'hA);
    check("nominal.not_yet_valid", 32'(config_valid), 32'h0);
    cycle(0, 0, 1, 4'h0);
    check("nominal.data", 32'(config_data), 32'h35A);
    check("nominal.valid", 32'(config_valid), 32'h1);
    check("nominal.busy", 32'(busy), 32'h0);

    // DONE ignores words and holds
    cycle(0, 0, 1, 4'h7);
    cycle(0, 0, 0, 4'h0);
    check("done.hold_data", 32'(config_data), 32'h35A);
    check("done.hold_valid", 32'(config_valid), 32'h1);

    // Bad checksum
    cycle(0, 1, 0, 4'h0);
    load(4'h1, 4'h2, 4'h3, 4'h1);
    check("badchk.error", 32'(error), 32'h1);
    check("badchk.data", 32'(config_data), 32'h0);
    check("badchk.valid", 32'(config_valid), 32'h0);
    check("badchk.ready", 32'(word_ready), 32'h0);
    cycle(0, 0, 0, 4'h0);
    check("badchk.hold", 32'(error), 32'h1);

    // Restart mid-load
    cycle(0, 1, 0, 4'h0);
    cycle(0, 0, 1, 4'h1);
    cycle(0, 0, 1, 4'h2);
    cycle(0, 1, 0, 4'h0);
    load(4'h3, 4'h4, 4'h5, 4'h2);
    check("restart.data", 32'(config_data), 32'h345);
    check("restart.valid", 32'(config_valid), 32'h1);

    // start coincident with a valid word: word dropped
    cycle(0, 1, 1, 4'h7);
    load(4'h1, 4'h2, 4'h3, 4'h0);
    check("collide.data", 32'(config_data), 32'h123);
    check("collide.valid", 32'(config_valid), 32'h1);

    // Asynchronous reset while waiting for the checksum
    cycle(0, 1, 0, 4'h0);
    cycle(0, 0, 1, 4'h6);
    cycle(0, 0, 1, 4'h7);
    cycle(0, 0, 1, 4'h8);
    check("prereset.busy", 32'(busy), 32'h1);
    config_reset = 1'b1;
    model_clear();
    #1;
    compare_all("async_reset");
    check("async_reset.data", 32'(config_data), 32'h0);
    check("async_reset.busy", 32'(busy), 32'h0);
    @(negedge config_clock);
    cycle(0, 0, 1, 4'h6);
    cycle(0, 0, 1, 4'h1);
    check("postreset.ignored", 32'(word_ready), 32'h0);

    // Continuous word_valid: complete in four accepted cycles
    cycle(0, 1, 0, 4'h0);
    load(4'h9, 4'hB, 4'hD, 4'h9 ^ 4'hB ^ 4'hD);
    check("stream.valid", 32'(config_valid), 32'h1);
    check("stream.data", 32'(config_data), 32'h1BD);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, st, v;
      logic [WW-1:0] w;
      r  = ($urandom % 150) == 0;
      st = ($urandom % 12) == 0;
      v  = ($urandom % 4) != 0;
      w  = WW'($urandom);
      if (m_active && m_q.size() == NW && ($urandom % 2) == 1)
        w = WW'(xor_of());
      cycle(r, st, v, w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
